// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: fetch sequencer states and the
// compressed-instruction detect used by fetch and decode.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FS_FETCH   = 2'd0,
    FS_WAIT    = 2'd1,
    FS_DELIVER = 2'd2,
    FS_DRAIN   = 2'd3
  } fetch_state_e;

  function automatic logic is_compressed(input logic [1:0] opcode);
    return opcode != 2'b11;
  endfunction

endpackage

// File: rtl/rv32_mod_fetch_align.sv
// Halfword selection / concatenation for the fetch sequencer: turns a fetched
// word (plus any saved spill halfword) into one instruction.
module rv32_mod_fetch_align
  import rv32_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic        pc_hi_i,
  input  logic        spill_i,
  input  logic [15:0] spare_i,
  output logic [31:0] instr_o,
  output logic        is_c_o,
  output logic        need_spill_o
);

  always_comb begin
    instr_o      = '0;
    is_c_o       = 1'b0;
    need_spill_o = 1'b0;
    if (spill_i) begin
      // Upper half of a word-spanning instruction arrives in the low half.
      instr_o = {word_i[15:0], spare_i};
    end else if (!pc_hi_i) begin
      if (is_compressed(word_i[1:0])) begin
        instr_o = {16'h0000, word_i[15:0]};
        is_c_o  = 1'b1;
      end else begin
        instr_o = word_i;
      end
    end else if (is_compressed(word_i[17:16])) begin
      instr_o = {16'h0000, word_i[31:16]};
      is_c_o  = 1'b1;
    end else begin
      need_spill_o = 1'b1;
    end
  end

endmodule

// File: rtl/rv32_mod_fetch_sequencer.sv
// RV32C instruction fetch sequencer: one outstanding word fetch, halfword
// alignment, word-spanning instructions, stall and redirect handling.
module rv32_mod_fetch_sequencer
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_is_compressed,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;
  logic [31:0]  buf_q, buf_d;
  logic [29:0]  bufw_q, bufw_d;
  logic [15:0]  spare_q, spare_d;
  logic         spill_q, spill_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         isc_q, isc_d;

  logic [31:0]  npc;
  logic [31:0]  eval_pc;
  logic [31:0]  spill_addr;
  logic [31:0]  al_word;
  logic         al_spill_in;
  logic [31:0]  al_instr;
  logic         al_c;
  logic         al_need_spill;
  logic         outstanding;

  // WAIT evaluates the arriving word at pc; DELIVER evaluates the buffer at the next pc.
  always_comb begin
    npc         = pc_q + (isc_q ? 32'd2 : 32'd4);
    eval_pc     = (state_q == FS_DELIVER) ? npc : pc_q;
    al_word     = (state_q == FS_DELIVER) ? buf_q : imem_rdata;
    al_spill_in = (state_q == FS_DELIVER) ? 1'b0 : spill_q;
    spill_addr  = eval_pc + 32'd2;
  end

  rv32_mod_fetch_align u_align (
    .word_i       (al_word),
    .pc_hi_i      (eval_pc[1]),
    .spill_i      (al_spill_in),
    .spare_i      (spare_q),
    .instr_o      (al_instr),
    .is_c_o       (al_c),
    .need_spill_o (al_need_spill)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    req_d       = req_q;
    buf_d       = buf_q;
    bufw_d      = bufw_q;
    spare_d     = spare_q;
    spill_d     = spill_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    isc_d       = isc_q;
    outstanding = 1'b0;

    case (state_q)
      FS_FETCH: begin
        if (!req_q) begin
          req_d = 1'b1;
        end else if (imem_ack) begin
          req_d   = 1'b0;
          state_d = FS_WAIT;
        end
      end

      FS_WAIT: begin
        if (imem_rvalid) begin
          buf_d  = imem_rdata;
          bufw_d = addr_q[31:2];
          if (al_need_spill) begin
            spare_d = imem_rdata[31:16];
            spill_d = 1'b1;
            addr_d  = spill_addr & ~32'd3;
            req_d   = 1'b1;
            state_d = FS_FETCH;
          end else begin
            spill_d = 1'b0;
            instr_d = al_instr;
            ipc_d   = pc_q;
            isc_d   = al_c;
            valid_d = 1'b1;
            state_d = FS_DELIVER;
          end
        end
      end

      FS_DELIVER: begin
        if (valid_q && instr_ready) begin
          pc_d    = npc;
          valid_d = 1'b0;
          if (npc[31:2] == bufw_q) begin
            if (al_need_spill) begin
              spare_d = buf_q[31:16];
              spill_d = 1'b1;
              addr_d  = spill_addr & ~32'd3;
              req_d   = 1'b1;
              state_d = FS_FETCH;
            end else begin
              instr_d = al_instr;
              ipc_d   = npc;
              isc_d   = al_c;
              valid_d = 1'b1;
            end
          end else begin
            addr_d  = npc & ~32'd3;
            req_d   = 1'b1;
            state_d = FS_FETCH;
          end
        end
      end

      FS_DRAIN: begin
        if (imem_rvalid) begin
          req_d   = 1'b1;
          state_d = FS_FETCH;
        end
      end

      default: begin
        state_d = FS_FETCH;
      end
    endcase

    // A response arriving in the redirect cycle closes the transaction, so no drain is needed.
    if (redirect_valid) begin
      outstanding = ((state_q == FS_FETCH) && req_q && imem_ack) ||
                    (((state_q == FS_WAIT) || (state_q == FS_DRAIN)) && !imem_rvalid);
      pc_d    = redirect_pc & ~32'd1;
      addr_d  = redirect_pc & ~32'd3;
      spill_d = 1'b0;
      valid_d = 1'b0;
      req_d   = !outstanding;
      state_d = outstanding ? FS_DRAIN : FS_FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC & ~32'd3;
      req_q   <= 1'b0;
      buf_q   <= '0;
      bufw_q  <= '0;
      spare_q <= '0;
      spill_q <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= RESET_PC;
      isc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      buf_q   <= buf_d;
      bufw_q  <= bufw_d;
      spare_q <= spare_d;
      spill_q <= spill_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      isc_q   <= isc_d;
    end
  end

  always_comb begin
    imem_req            = req_q;
    imem_addr           = addr_q;
    instr_valid         = valid_q && !redirect_valid;
    instr               = instr_q;
    instr_pc            = ipc_q;
    instr_is_compressed = isc_q;
  end

endmodule
